// File: rtl/if_fetch_pkg.sv
// Shared widths, reset constants, decode payload type and PC helpers for the fetch stage.
package if_fetch_pkg;

  localparam int unsigned REG_BUS  = 64;
  localparam int unsigned INST_BUS = 32;

  localparam logic [REG_BUS-1:0]  RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [INST_BUS-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Payload held for decode while an instruction is presented
  typedef struct packed {
    logic [REG_BUS-1:0]  pc;
    logic [INST_BUS-1:0] inst;
    logic                misalign;
  } fetch_out_t;

  // Sequential successor, wraps modulo 2^64
  function automatic logic [REG_BUS-1:0] pc_plus4(input logic [REG_BUS-1:0] pc);
    return pc + REG_BUS'(4);
  endfunction

  // Instructions must be word aligned
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem read at a time
// and presents {pc, inst} to decode over a valid/ready handshake.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [REG_BUS-1:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_BUS-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [REG_BUS-1:0]  redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [REG_BUS-1:0]  imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_BUS-1:0] imem_resp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [REG_BUS-1:0]  if_pc,
  output logic [INST_BUS-1:0] if_inst,
  output logic                if_misalign
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [REG_BUS-1:0] pc_q, pc_d;
  fetch_out_t         out_q, out_d;
  logic               req_c;
  logic               req_fire_c;

  // Request is only legal from S_REQ with an aligned PC
  assign req_c      = (state_q == S_REQ) && !pc_misaligned(pc_q[1:0]);
  assign req_fire_c = req_c && imem_req_ready;

  // State, PC and presented-payload registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      out_q.pc       <= RESET_PC;
      out_q.inst     <= NOP_INST;
      out_q.misalign <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Next state; redirect wins in every state and retires any in-flight read as stale
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = req_fire_c ? S_DROP : S_REQ;
        end else if (pc_misaligned(pc_q[1:0])) begin
          out_d.pc       = pc_q;
          out_d.inst     = NOP_INST;
          out_d.misalign = 1'b1;
          state_d        = S_OUT;
        end else if (req_fire_c) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          out_d.pc       = pc_q;
          out_d.inst     = imem_resp_data;
          out_d.misalign = 1'b0;
          state_d        = S_OUT;
        end
      end
      S_DROP: begin
        // A redirect here only retargets; the stale response still retires the drop
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_plus4(pc_q);
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Outputs decode registered state only; nothing from if_ready/redirect reaches if_valid
  always_comb begin
    imem_req_valid = reset && req_c;
    imem_req_addr  = pc_q;
    if_valid       = (state_q == S_OUT);
    if_pc          = out_q.pc;
    if_inst        = NOP_INST;
    if_misalign    = 1'b0;
    if (state_q == S_OUT) begin
      if_inst     = out_q.inst;
      if_misalign = out_q.misalign;
    end
  end

  // A response is only expected while a read is outstanding
  resp_in_window: assert property (@(posedge clock) disable iff (!reset)
    imem_resp_valid |-> (state_q == S_WAIT || state_q == S_DROP));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed stimulus, a transaction-level fetch model
// checked every cycle, and hand-computed pins at key points.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  if_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_misalign    (if_misalign)
  );

  initial forever #5 clock = ~clock;

  // Memory contents are a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory responder ----------------
  int          rsp_lat = 1;
  int          rsp_cnt = 0;
  logic [63:0] rsp_addr = '0;

  initial begin
    logic        will_accept;
    logic [63:0] acc_addr;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clock);
      #2;
      imem_resp_valid = 1'b0;
      if (rsp_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(rsp_addr[31:0]);
      end
      if (rsp_cnt > 0) rsp_cnt--;
      will_accept = reset && imem_req_valid && imem_req_ready;
      acc_addr    = imem_req_addr;
      @(posedge clock);
      if (will_accept) begin
        rsp_cnt  = rsp_lat;
        rsp_addr = acc_addr;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_out: a read is in flight; m_stale: that read's data must be thrown away;
  // m_held: an instruction is being offered to decode.
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_held, m_hmis;
  logic [63:0] m_hpc;
  logic [31:0] m_hinst;

  function automatic bit model_req();
    return !m_held && !m_out && (m_pc[1:0] == 2'b00);
  endfunction

  initial begin
    bit accept, got;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_pc = RST_PC; m_out = 0; m_stale = 0; m_held = 0;
        m_hpc = RST_PC; m_hinst = NOP; m_hmis = 0;
      end else begin
        accept = model_req() && imem_req_ready;
        got    = imem_resp_valid && m_out;
        if (redirect_valid) begin
          m_out   = (m_out && !got) || accept;
          m_stale = m_out;
          m_held  = 0;
          m_pc    = redirect_pc;
        end else if (m_held) begin
          if (if_ready) begin
            m_held = 0;
            m_pc   = m_pc + 64'd4;
          end
        end else if (m_out) begin
          if (got) begin
            if (!m_stale) begin
              m_held = 1; m_hpc = m_pc; m_hinst = imem_resp_data; m_hmis = 0;
            end
            m_out = 0; m_stale = 0;
          end
        end else if (m_pc[1:0] != 2'b00) begin
          m_held = 1; m_hpc = m_pc; m_hinst = NOP; m_hmis = 1;
        end else if (imem_req_ready) begin
          m_out = 1; m_stale = 0;
        end
      end
    end
  end

  // ---------------- pins set by the stimulus thread ----------------
  int          pin_seq = 0;
  int          pin_kind = 0;   // 1 reset, 2 presenting, 3 requesting, 4 idle
  logic [63:0] pin_pc = '0;
  logic [31:0] pin_inst = '0;
  logic        pin_mis = 1'b0;
  bit          done = 0;

  task automatic pin_reset();
    pin_kind = 1; pin_seq++;
  endtask
  task automatic pin_out(input logic [63:0] pc, input logic [31:0] inst, input logic mis);
    pin_kind = 2; pin_pc = pc; pin_inst = inst; pin_mis = mis; pin_seq++;
  endtask
  task automatic pin_req(input logic [63:0] addr);
    pin_kind = 3; pin_pc = addr; pin_seq++;
  endtask
  task automatic pin_idle();
    pin_kind = 4; pin_seq++;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- compare process ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  initial begin
    int pin_seen = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        chk("model.req_valid", 64'(imem_req_valid), 64'(model_req()));
        if (model_req()) chk("model.req_addr", imem_req_addr, m_pc);
        chk("model.if_valid", 64'(if_valid), 64'(m_held));
        if (m_held) begin
          chk("model.if_pc", if_pc, m_hpc);
          chk("model.if_inst", 64'(if_inst), 64'(m_hinst));
          chk("model.if_misalign", 64'(if_misalign), 64'(m_hmis));
        end else begin
          chk("model.if_inst_idle", 64'(if_inst), 64'(NOP));
          chk("model.if_misalign_idle", 64'(if_misalign), 64'd0);
        end
      end
      if (pin_seq != pin_seen) begin
        pin_seen = pin_seq;
        case (pin_kind)
          1: begin
            chk("pin.rst_if_valid", 64'(if_valid), 64'd0);
            chk("pin.rst_if_pc", if_pc, RST_PC);
            chk("pin.rst_if_inst", 64'(if_inst), 64'(NOP));
            chk("pin.rst_if_misalign", 64'(if_misalign), 64'd0);
            chk("pin.rst_req_valid", 64'(imem_req_valid), 64'd0);
          end
          2: begin
            chk("pin.out_if_valid", 64'(if_valid), 64'd1);
            chk("pin.out_if_pc", if_pc, pin_pc);
            chk("pin.out_if_inst", 64'(if_inst), 64'(pin_inst));
            chk("pin.out_if_misalign", 64'(if_misalign), 64'(pin_mis));
            chk("pin.out_no_req", 64'(imem_req_valid), 64'd0);
          end
          3: begin
            chk("pin.req_valid", 64'(imem_req_valid), 64'd1);
            chk("pin.req_addr", imem_req_addr, pin_pc);
            chk("pin.req_if_valid", 64'(if_valid), 64'd0);
          end
          default: begin
            chk("pin.idle_req_valid", 64'(imem_req_valid), 64'd0);
            chk("pin.idle_if_valid", 64'(if_valid), 64'd0);
          end
        endcase
      end
      if (done) begin
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1;

    // Reset state, then sequential fetch with 1-cycle memory
    tick(3); pin_reset();
    tick(1); reset = 1'b1;
    tick(2); pin_out(64'h8000_0000, 32'hDA5A_0000, 1'b0);
    tick(1); pin_req(64'h8000_0004);
    tick(2); pin_out(64'h8000_0004, 32'hDA5A_0004, 1'b0);
    tick(3); pin_out(64'h8000_0008, 32'hDA5A_0008, 1'b0); if_ready = 1'b0;

    // Decode stalls: payload held, no new request
    for (int i = 0; i < 5; i++) begin
      tick(1); pin_out(64'h8000_0008, 32'hDA5A_0008, 1'b0);
    end
    if_ready = 1'b1; rsp_lat = 3;

    // Redirect while waiting; late response is dropped
    tick(1); pin_req(64'h8000_000C);
    tick(1); redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick(1); redirect_valid = 1'b0; rsp_lat = 1; pin_idle();
    tick(1); pin_idle();
    tick(1); pin_req(64'h8000_0100);

    // Redirect coinciding with a decode handshake
    tick(2); pin_out(64'h8000_0100, 32'hDA5A_0100, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick(1); redirect_valid = 1'b0; pin_req(64'h8000_0200);
    tick(2); pin_out(64'h8000_0200, 32'hDA5A_0200, 1'b0);

    // Misaligned target, redirect lands on a same-cycle accept
    tick(1); pin_req(64'h8000_0204);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; if_ready = 1'b0;
    tick(1); redirect_valid = 1'b0; pin_idle();
    tick(1); pin_idle();
    tick(1); pin_out(64'h8000_0102, NOP, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; rsp_lat = 3;

    // Reset asserted mid-wait; response arrives while in reset
    tick(1); redirect_valid = 1'b0; pin_req(64'h8000_0300);
    tick(1); reset = 1'b0; pin_reset(); rsp_lat = 1;
    tick(1); pin_reset();
    tick(1); pin_reset();
    tick(1); reset = 1'b1; pin_req(RST_PC);
    tick(2); pin_out(RST_PC, 32'hDA5A_0000, 1'b0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(1); redirect_valid = 1'b0; pin_req(64'hFFFF_FFFF_FFFF_FFFC);
    tick(2); pin_out(64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5_FFFC, 1'b0); if_ready = 1'b1;
    tick(1); pin_req(64'h0); if_ready = 1'b0;
    tick(3);
    done = 1;
  end

endmodule
